vector_lane_alu: RTL

// Multi-cycle, lane-parallel element-wise vector ALU: successor to the single-shot per-element ALU.

---
 rtl/vector_lane_alu.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/vector_lane_alu.sv
// vector_lane_alu
//   Multi-cycle, lane-parallel element-wise vector ALU. A vector of up to N elements is
//   processed through LANES shared ALU lanes, ceil(len/LANES) beats per operation, with a
//   start/busy/done handshake and a registered result file S plus its length S_len.
//
//   Build option: define VECTOR_LANE_ALU_SATURATE_EN to clamp add/sub/mult results to the
//   signed BITS range; when undefined those results wrap (low BITS bits of the wide result).
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   A, A_len         operand vector A and its valid length
//   B, B_len         operand vector B and its valid length
//   scalar           broadcast operand used instead of B when scalar_sel=1
//   scalar_sel       selects scalar as the B operand for every element
//   op_sel           000 add, 001 sub, 010 mult, 011 signed cmp, 100 and, 101 or, 110 xor, 111 not A
//   start            one-cycle request, only honoured while idle
//   busy             high while running or signalling completion
//   done             one-cycle pulse once S/S_len hold the final result
//   S, S_len         result register file and result length
module vector_lane_alu #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned N          = 64,
  parameter int unsigned LANES      = 4,
  parameter int unsigned MULT_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] A [N-1:0],
  input  logic [7:0]      A_len,
  input  logic [BITS-1:0] B [N-1:0],
  input  logic [7:0]      B_len,
  input  logic [BITS-1:0] scalar,
  input  logic            scalar_sel,
  input  logic [2:0]      op_sel,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] S [N-1:0],
  output logic [7:0]      S_len
);

  localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WideW = 2 * BITS;
  localparam logic [7:0]  NLen  = 8'(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      beat_q;
  logic [7:0]      len_q;
  logic [2:0]      op_q;
  logic            ssel_q;
  logic [BITS-1:0] scalar_q;
  logic [BITS-1:0] s_q [N-1:0];
  logic [7:0]      s_len_q;

  logic [7:0]      len_max;
  logic [7:0]      len_in;
  logic            last_beat;
  logic [15:0]     lane_idx [LANES];
  logic [BITS-1:0] lane_a   [LANES];
  logic [BITS-1:0] lane_b   [LANES];
  logic [BITS-1:0] lane_res [LANES];

  // Reduce a wide signed arithmetic result to BITS, clamping or wrapping per build option.
  function automatic logic [BITS-1:0] reduce(input logic signed [WideW-1:0] v);
`ifdef VECTOR_LANE_ALU_SATURATE_EN
    logic signed [WideW-1:0] hi;
    logic signed [WideW-1:0] lo;
    hi = {{(WideW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    lo = {{(WideW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    if (v > hi) begin
      return hi[BITS-1:0];
    end else if (v < lo) begin
      return lo[BITS-1:0];
    end
    return v[BITS-1:0];
`else
    return BITS'(v);
`endif
  endfunction

  function automatic logic [BITS-1:0] alu(input logic [2:0]      op,
                                          input logic [BITS-1:0] a,
                                          input logic [BITS-1:0] b);
    logic signed [WideW-1:0] ax;
    logic signed [WideW-1:0] bx;
    logic [BITS-1:0]         r;
    // Sign-extend so add/sub/mult are exact in WideW before reduction.
    ax = WideW'($signed(a));
    bx = WideW'($signed(b));
    r  = '0;
    case (op)
      3'b000: r = reduce(ax + bx);
      3'b001: r = reduce(ax - bx);
      3'b010: r = reduce((ax * bx) >>> MULT_SHIFT);
      3'b011: begin
        if ($signed(a) > $signed(b)) begin
          r = BITS'(1);
        end else if (a == b) begin
          r = '0;
        end else begin
          r = '1;
        end
      end
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Effective length: the longer operand, capped at the register file size.
  always_comb begin
    len_max = (A_len > B_len) ? A_len : B_len;
    len_in  = (len_max > NLen) ? NLen : len_max;
  end

  always_comb begin
    last_beat = ((16'(beat_q) + 16'd1) * 16'(LANES)) >= 16'(len_q);
  end

  // Lane operand fetch; indices past N (partial final beat) read zero and are never written.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 16'(beat_q) * 16'(LANES) + 16'(l);
      lane_a[l]   = '0;
      lane_b[l]   = scalar_q;
      if (lane_idx[l] < 16'(N)) begin
        lane_a[l] = A[lane_idx[l][IdxW-1:0]];
        if (!ssel_q) begin
          lane_b[l] = B[lane_idx[l][IdxW-1:0]];
        end
      end
      lane_res[l] = alu(op_q, lane_a[l], lane_b[l]);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len_in == 8'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_beat) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Datapath: command latch, beat counter, result file and length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      len_q    <= '0;
      op_q     <= '0;
      ssel_q   <= 1'b0;
      scalar_q <= '0;
      s_len_q  <= '0;
      for (int i = 0; i < N; i++) begin
        s_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            beat_q   <= '0;
            len_q    <= len_in;
            op_q     <= op_sel;
            ssel_q   <= scalar_sel;
            scalar_q <= scalar;
            // Zero-length ops skip RUN, so publish the length now.
            if (len_in == 8'd0) begin
              s_len_q <= len_in;
            end
          end
        end
        StRun: begin
          beat_q <= beat_q + 8'd1;
          for (int i = 0; i < N; i++) begin
            if ((8'(i) < len_q) && (8'(i / LANES) == beat_q)) begin
              s_q[i] <= lane_res[i % LANES];
            end
          end
          // Length becomes visible together with done.
          if (last_beat) begin
            s_len_q <= len_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign S     = s_q;
  assign S_len = s_len_q;

endmodule
